clock_div_gen: RTL and testbench
================================

// Module: clock_div_gen
// PURPOSE
//  Synthesisable, programmable successor to the behavioural clock generator.
//  Derives a divided clock waveform (clk_out) from the system clock, with runtime-programmable
//    LOW and HIGH phase lengths, so duty cycle is arbitrary, not fixed at 50%.
//  Start/stop is glitch-free.
//  Provides single-cycle rise/fall tick strobes; downstream logic should use these as clock enables.
// PARAMETERS
//  WIDTH         16  bit width of phase-length counters and config inputs
//  DEFAULT_LOW   5   LOW phase length in clk cycles after reset; must be 1..2^WIDTH-1
//  DEFAULT_HIGH  5   HIGH phase length in clk cycles after reset; must be 1..2^WIDTH-1
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  enable     in   1      level: run divided clock while high
//  load       in   1      1-cycle strobe: capture low_cnt/high_cnt into config registers
//  low_cnt    in   WIDTH  requested LOW phase length (cycles)
//  high_cnt   in   WIDTH  requested HIGH phase length (cycles)
//  clk_out    out  1      divided clock, registered
//  rise_tick  out  1      high for exactly the first cycle of each HIGH phase
//  fall_tick  out  1      high for the first cycle clk_out returns to 0 after a HIGH phase
//  running    out  1      1 while state != IDLE
//  cfg_err    out  1      1-cycle pulse: a load was rejected
// BEHAVIOUR
//  Reset: state=IDLE; clk_out=0; rise_tick=0; fall_tick=0; running=0; cfg_err=0.
//    Config regs lo_r=DEFAULT_LOW, hi_r=DEFAULT_HIGH.
//    rst mid-operation: all of the above take effect at the next edge; no waveform completion.
//  Waveform states: IDLE, LOW, HIGH.
//    Down-counter cnt[WIDTH-1:0] is loaded with (phase length - 1) on each phase entry.
//    The phase ends when cnt==0.
//  IDLE:
//    enable=1 sampled at edge t -> LOW from edge t+1; cnt=lo_r-1; running=1.
//  LOW:
//    clk_out=0 for exactly lo_r cycles.
//    At cnt==0 -> HIGH; cnt=hi_r-1; clk_out=1; rise_tick=1 for that cycle.
//  HIGH:
//    clk_out=1 for exactly hi_r cycles.
//    At cnt==0:
//      if enable=1 -> LOW; cnt=lo_r-1.
//      else -> IDLE; running=0.
//    In both cases clk_out=0 and fall_tick=1 for that cycle.
//  Stop rule: enable is sampled only at the HIGH->next boundary.
//    Dropping enable mid-period always completes the full period.
//    Never a truncated HIGH or LOW phase.
//    Re-asserting enable before the boundary continues with no gap.
//  Period = lo_r + hi_r cycles.
//    The first rise occurs lo_r cycles after the LOW entry.
//  Phase length 1 is legal. lo_r=hi_r=1 toggles clk_out every cycle (clk/2).
//  Config load (load=1 at edge):
//    Accepted only in IDLE with low_cnt!=0 and high_cnt!=0. lo_r/hi_r update at that edge.
//    Rejected when state!=IDLE or either value is 0: config unchanged; cfg_err=1 next cycle.
//    load and enable in the same IDLE cycle: new config is used for the starting period.
//  Ticks are registered and coincide with the clk_out transition cycle.
//    rise_tick and fall_tick are never both high.
// TESTING
//  T1 rst, then enable=1 from cycle 0, defaults:
//     clk_out=0 cycles 1-5, 1 cycles 6-10, 0 cycles 11-15.
//     rise_tick @6,16; fall_tick @11,21.
//  T2 load low=1,high=1 in IDLE, enable=1:
//     clk_out alternates every cycle; period 2; cfg_err stays 0.
//  T3 load low=7,high=3:
//     clk_out low 7 / high 3 cycles repeatedly; 10-cycle period.
//  T4 defaults, enable dropped 2 cycles into LOW:
//     full 5-cycle HIGH still produced, then fall_tick and running=0; no further rise_tick.
//  T5 load while running, and load high_cnt=0 in IDLE:
//     cfg_err 1-cycle pulse each time; waveform and config unchanged.
//  T6 rst asserted mid HIGH:
//     next cycle clk_out=0, running=0, ticks 0.
//     Restart with enable=1 gives the default 5/5 waveform.

Source files
------------

// File: rtl/clock_div_gen.sv
// Programmable clock divider: independent LOW/HIGH phase lengths, glitch-free start/stop
// at period boundaries, and single-cycle rise/fall strobes for use as clock enables.
module clock_div_gen #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_LOW  = 5,
    parameter int DEFAULT_HIGH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] low_cnt,
    input  logic [WIDTH-1:0] high_cnt,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             running,
    output logic             cfg_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DEF_LO = WIDTH'(DEFAULT_LOW);
    localparam logic [WIDTH-1:0] DEF_HI = WIDTH'(DEFAULT_HIGH);

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic             clk_out_r, clk_out_s;
    logic             rise_tick_r, rise_tick_s;
    logic             fall_tick_r, fall_tick_s;
    logic             running_r, running_s;
    logic             cfg_err_r, cfg_err_s;
    logic             load_ok_s;

    assign load_ok_s = load && (state_r == IDLE) && (low_cnt != ZERO) && (high_cnt != ZERO);

    // Next-state logic: config capture and the IDLE/LOW/HIGH waveform sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        lo_s        = lo_r;
        hi_s        = hi_r;
        clk_out_s   = clk_out_r;
        rise_tick_s = 1'b0;
        fall_tick_s = 1'b0;
        running_s   = running_r;
        cfg_err_s   = 1'b0;

        if (load_ok_s) begin
            lo_s = low_cnt;
            hi_s = high_cnt;
        end else begin
            cfg_err_s = load;
        end

        case (state_r)
            IDLE: begin
                clk_out_s = 1'b0;
                // lo_s so a load accepted together with enable shapes the first period
                if (enable) begin
                    state_s   = LOW;
                    cnt_s     = lo_s - ONE;
                    running_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                    running_s = 1'b0;
                end
            end
            LOW: begin
                if (cnt_r == ZERO) begin
                    state_s     = HIGH;
                    cnt_s       = hi_r - ONE;
                    clk_out_s   = 1'b1;
                    rise_tick_s = 1'b1;
                end else begin
                    cnt_s     = cnt_r - ONE;
                    clk_out_s = 1'b0;
                end
            end
            HIGH: begin
                // enable only matters here, so a stop never truncates a phase
                if (cnt_r == ZERO) begin
                    clk_out_s   = 1'b0;
                    fall_tick_s = 1'b1;
                    if (enable) begin
                        state_s = LOW;
                        cnt_s   = lo_r - ONE;
                    end else begin
                        state_s   = IDLE;
                        cnt_s     = ZERO;
                        running_s = 1'b0;
                    end
                end else begin
                    cnt_s     = cnt_r - ONE;
                    clk_out_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = ZERO;
                clk_out_s = 1'b0;
                running_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= ZERO;
            lo_r        <= DEF_LO;
            hi_r        <= DEF_HI;
            clk_out_r   <= 1'b0;
            rise_tick_r <= 1'b0;
            fall_tick_r <= 1'b0;
            running_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            lo_r        <= lo_s;
            hi_r        <= hi_s;
            clk_out_r   <= clk_out_s;
            rise_tick_r <= rise_tick_s;
            fall_tick_r <= fall_tick_s;
            running_r   <= running_s;
            cfg_err_r   <= cfg_err_s;
        end
    end

    assign clk_out   = clk_out_r;
    assign rise_tick = rise_tick_r;
    assign fall_tick = fall_tick_r;
    assign running   = running_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_clock_div_gen.sv
// Scoreboard bench for clock_div_gen: each driven cycle pushes the expected
// {clk_out, rise_tick, fall_tick, running, cfg_err} vector, a monitor pops and compares.
module tb_clock_div_gen;

    localparam int BIG = 100000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] low_cnt;
    logic [15:0] high_cnt;
    logic        clk_out;
    logic        rise_tick;
    logic        fall_tick;
    logic        running;
    logic        cfg_err;

    typedef struct {
        string      tag;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks_s;
    int   errors_s;

    clock_div_gen #(.WIDTH(16), .DEFAULT_LOW(5), .DEFAULT_HIGH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .load     (load),
        .low_cnt  (low_cnt),
        .high_cnt (high_cnt),
        .clk_out  (clk_out),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .running  (running),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got {clk,rise,fall,run,err}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare registered outputs 1 time unit after each edge.
    always @(posedge clk) begin
        exp_t item;
        #1;
        if (sb.size() != 0) begin
            item = sb.pop_front();
            check_val(item.tag, {clk_out, rise_tick, fall_tick, running, cfg_err}, item.v);
        end
    end

    task automatic step(input logic r, input logic en, input logic ld,
                        input logic [15:0] lc, input logic [15:0] hc,
                        input logic [4:0] e, input string tag);
        exp_t item;
        rst      = r;
        enable   = en;
        load     = ld;
        low_cnt  = lc;
        high_cnt = hc;
        item.tag = tag;
        item.v   = e;
        sb.push_back(item);
        @(posedge clk);
        #2;
    endtask

    // Expected waveform from phase lengths: nper full periods starting from IDLE, then stop.
    // enable held for the first keep steps (always high at period starts), low at the stop.
    task automatic wave(input string tag, input int lo, input int hi, input int nper,
                        input int keep, input logic ld0, input int ldk,
                        input logic [15:0] lc, input logic [15:0] hc);
        int   k;
        logic en;
        logic ld;
        k = 0;
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < lo; i++) begin
                en = (k == 0 || (i == 0 && p > 0)) ? 1'b1 : (k < keep);
                ld = (k == 0 && ld0) || (k == ldk);
                step(1'b0, en, ld, lc, hc,
                     {1'b0, 1'b0, (i == 0 && p > 0), 1'b1, (k == ldk)}, {tag, "_low"});
                k++;
            end
            for (int i = 0; i < hi; i++) begin
                en = (k < keep);
                ld = (k == ldk);
                step(1'b0, en, ld, lc, hc,
                     {1'b1, (i == 0), 1'b0, 1'b1, (k == ldk)}, {tag, "_high"});
                k++;
            end
        end
        step(1'b0, 1'b0, (k == ldk), lc, hc, {1'b0, 1'b0, 1'b1, 1'b0, (k == ldk)}, {tag, "_stop"});
    endtask

    initial begin
        checks_s = 0;
        errors_s = 0;
        rst = 1'b1; enable = 1'b0; load = 1'b0; low_cnt = 16'd0; high_cnt = 16'd0;
        #2;

        // Reset with enable high: outputs must still be all zero
        step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 5'b00000, "reset");
        // T1 defaults 5/5, two periods
        wave("t1", 5, 5, 2, BIG, 1'b0, -1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 5'b00000, "t1_idle");
        // T2 load 1/1 together with enable
        wave("t2", 1, 1, 3, BIG, 1'b1, -1, 16'd1, 16'd1);
        // T3 load 7/3
        wave("t3", 7, 3, 2, BIG, 1'b1, -1, 16'd7, 16'd3);
        // T4 restore defaults, then drop enable two cycles into LOW
        step(1'b0, 1'b0, 1'b1, 16'd5, 16'd5, 5'b00000, "t4_load");
        wave("t4", 5, 5, 1, 3, 1'b0, -1, 16'd0, 16'd0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 5'b00000, "t4_quiet");
        // T5 rejected loads: zero high in IDLE, then a load while running
        step(1'b0, 1'b0, 1'b1, 16'd4, 16'd0, 5'b00001, "t5_zero");
        step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 5'b00000, "t5_pulse_end");
        wave("t5", 5, 5, 2, BIG, 1'b0, 3, 16'd9, 16'd9);
        // T6 reset in the middle of HIGH, then restart with defaults
        step(1'b0, 1'b0, 1'b1, 16'd2, 16'd3, 5'b00000, "t6_load");
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 5'b00010, "t6_low");
        step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 5'b11010, "t6_rise");
        step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 5'b10010, "t6_high");
        step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 5'b00000, "t6_rst");
        wave("t6", 5, 5, 1, BIG, 1'b0, -1, 16'd0, 16'd0);

        rst = 1'b0; enable = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_val("drain", 5'(sb.size()), 5'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
        $finish;
    end

endmodule
